conv_kxk_mc: RTL and testbench

Parametrised multi-channel K×K convolution engine with a ready/valid stream interface. Each accepted beat carries one K×K input window for one input channel. The block multiplies the window by the matching filter slice and accumulates over C_IN channels on top of a sign-extended bias. It emits one signed result per C_IN beats. It is the successor to the fixed 5×5×3 convolution unit in the LeNet-5 datapath. It time-multiplexes channels through a single K×K MAC tree instead of instantiating one tree per channel.

---
 rtl/conv_kxk_mc.sv | 104 ++++++++++
 tb/tb_conv_kxk_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_kxk_mc.sv
// Multi-channel KxK convolution: one window beat per input channel, accumulated over C_IN beats
// through a single shared MAC tree. Optional macro CONV_RELU_EN clamps the emitted result at zero.
module conv_kxk_mc #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned K         = 5,
    parameter int unsigned C_IN      = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [BIT_WIDTH*K*K-1:0]              window,
    input  logic [BIT_WIDTH*K*K*C_IN-1:0]         filter,
    input  logic [BIT_WIDTH-1:0]                  bias,
    output logic [(C_IN > 1 ? $clog2(C_IN) : 1)-1:0] ch_idx,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_WIDTH-1:0]                  conv_value
);

    localparam int unsigned KK  = K * K;
    localparam int unsigned ChW = (C_IN > 1) ? $clog2(C_IN) : 1;
    localparam int unsigned PW  = 2 * BIT_WIDTH;

    logic [ChW-1:0]              ch_q, ch_d;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0]        conv_q, conv_d;
    logic                        out_valid_q, out_valid_d;

    logic                        accept;
    logic                        last_ch;
    int unsigned                 ch_base;
    logic signed [BIT_WIDTH-1:0] w_el, f_el;
    logic signed [PW-1:0]        prod;
    logic signed [OUT_WIDTH-1:0] partial;
    logic signed [OUT_WIDTH-1:0] bias_ext;
    logic signed [OUT_WIDTH-1:0] acc_base;
    logic signed [OUT_WIDTH-1:0] sum;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_ch    = (ch_q == ChW'(C_IN - 1));
    assign ch_idx     = ch_q;
    assign out_valid  = out_valid_q;
    assign conv_value = conv_q;

    // Dot product of the window with the filter slice of the current channel.
    always_comb begin
        ch_base = int'(ch_q) * KK;
        partial = '0;
        w_el    = '0;
        f_el    = '0;
        prod    = '0;
        for (int i = 0; i < int'(KK); i++) begin
            w_el    = signed'(window[BIT_WIDTH*i +: BIT_WIDTH]);
            f_el    = signed'(filter[BIT_WIDTH*(ch_base + i) +: BIT_WIDTH]);
            prod    = PW'(w_el) * PW'(f_el);
            partial = partial + OUT_WIDTH'(prod);
        end
    end

    always_comb begin
        bias_ext = OUT_WIDTH'(signed'(bias));
        acc_base = (ch_q == '0) ? bias_ext : acc_q;
        sum      = acc_base + partial;
    end

    always_comb begin
        ch_d        = ch_q;
        acc_d       = acc_q;
        conv_d      = conv_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            acc_d = sum;
            if (last_ch) begin
                ch_d        = '0;
                out_valid_d = 1'b1;
`ifdef CONV_RELU_EN
                conv_d      = sum[OUT_WIDTH-1] ? '0 : sum;
`else
                conv_d      = sum;
`endif
            end else begin
                ch_d = ch_q + ChW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q        <= '0;
            acc_q       <= '0;
            conv_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            conv_q      <= conv_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_conv_kxk_mc.sv
// Directed bench for conv_kxk_mc: vector table on the default 5x5x3 instance plus
// hand sequences for element placement, backpressure and a single-channel instance.
module tb_conv_kxk_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [199:0] window;
    logic [599:0] filter;
    logic [7:0]  bias;
    logic [1:0]  ch_idx;
    logic [31:0] conv_value;

    logic        iv1, ir1, ov1, ordy1;
    logic [7:0]  w1, f1, b1;
    logic [0:0]  ch1;
    logic [31:0] cv1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_kxk_mc #(.BIT_WIDTH(8), .OUT_WIDTH(32), .K(5), .C_IN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .window    (window),
        .filter    (filter),
        .bias      (bias),
        .ch_idx    (ch_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .conv_value(conv_value)
    );

    conv_kxk_mc #(.BIT_WIDTH(8), .OUT_WIDTH(32), .K(1), .C_IN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .window    (w1),
        .filter    (f1),
        .bias      (b1),
        .ch_idx    (ch1),
        .out_valid (ov1),
        .out_ready (ordy1),
        .conv_value(cv1)
    );

    typedef struct {
        logic rst, iv, ordy;
        int   w, f, b;
        int   e_ir, e_ov, e_ch, e_cv;
    } vec_t;

    localparam int NV = 40;
    localparam int E2 = -406400;
    vec_t tbl[NV];

    function automatic int relu(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic iv, input logic o, input int w,
                                input int f, input int b, input int ir, input int ov,
                                input int ch, input int cv);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = o; v.w = w; v.f = f; v.b = b;
        v.e_ir = ir; v.e_ov = ov; v.e_ch = ch; v.e_cv = cv;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [7:0] wb, fb;

        // Rows: rst, in_valid, out_ready, win, filt, bias | in_ready, out_valid, ch_idx, conv
        tbl[0]  = mk(0, 1, 1,    1,   1,  2, 1, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1,    1,   1,  2, 1, 0, 1, 0);
        tbl[2]  = mk(0, 1, 1,    1,   1,  2, 1, 0, 2, 0);
        tbl[3]  = mk(0, 0, 1,    1,   1,  2, 1, 1, 0, 77);
        tbl[4]  = mk(0, 1, 1, -128, 127,  0, 1, 0, 0, 77);
        tbl[5]  = mk(0, 1, 1,    0, 127,  0, 1, 0, 1, 77);
        tbl[6]  = mk(0, 1, 1,    0, 127,  0, 1, 0, 2, 77);
        tbl[7]  = mk(0, 0, 1,    0, 127,  0, 1, 1, 0, E2);
        tbl[8]  = mk(0, 1, 1,    1,   1,  2, 1, 0, 0, E2);
        tbl[9]  = mk(0, 1, 1,    1,   1,  2, 1, 0, 1, E2);
        tbl[10] = mk(0, 1, 1,    1,   1,  2, 1, 0, 2, E2);
        tbl[11] = mk(0, 1, 0,    1,   1,  2, 0, 1, 0, 77);
        tbl[12] = mk(0, 1, 0,    1,   1,  2, 0, 1, 0, 77);
        tbl[13] = mk(0, 1, 0,    1,   1,  2, 0, 1, 0, 77);
        tbl[14] = mk(0, 1, 0,    1,   1,  2, 0, 1, 0, 77);
        tbl[15] = mk(0, 1, 1,    1,   1,  2, 1, 1, 0, 77);
        tbl[16] = mk(0, 1, 1,    1,   1,  2, 1, 0, 1, 77);
        tbl[17] = mk(0, 1, 1,    1,   1,  2, 1, 0, 2, 77);
        tbl[18] = mk(0, 0, 1,    1,   1,  2, 1, 1, 0, 77);
        tbl[19] = mk(0, 1, 1,    1,   1,  2, 1, 0, 0, 77);
        tbl[20] = mk(0, 0, 1,    1,   1,  2, 1, 0, 1, 77);
        tbl[21] = mk(0, 0, 1,    1,   1,  2, 1, 0, 1, 77);
        tbl[22] = mk(0, 1, 1,    1,   1,  2, 1, 0, 1, 77);
        tbl[23] = mk(0, 0, 1,    1,   1,  2, 1, 0, 2, 77);
        tbl[24] = mk(0, 1, 1,    1,   1,  2, 1, 0, 2, 77);
        tbl[25] = mk(0, 0, 1,    1,   1,  2, 1, 1, 0, 77);
        tbl[26] = mk(0, 1, 1,    1,   1,  2, 1, 0, 0, 77);
        tbl[27] = mk(0, 1, 1,    1,   1,  2, 1, 0, 1, 77);
        tbl[28] = mk(0, 1, 1,    1,   1,  2, 1, 0, 2, 77);
        tbl[29] = mk(0, 1, 1,    1,   1, -5, 1, 1, 0, 77);
        tbl[30] = mk(0, 1, 1,    1,   1, -5, 1, 0, 1, 77);
        tbl[31] = mk(0, 1, 1,    1,   1, -5, 1, 0, 2, 77);
        tbl[32] = mk(0, 0, 1,    1,   1, -5, 1, 1, 0, 70);
        tbl[33] = mk(0, 1, 1,    1,   1,  2, 1, 0, 0, 70);
        tbl[34] = mk(0, 1, 1,    1,   1,  2, 1, 0, 1, 70);
        tbl[35] = mk(1, 1, 1,    1,   1,  2, 1, 0, 2, 70);
        tbl[36] = mk(0, 1, 1,    1,   1,  0, 1, 0, 0, 0);
        tbl[37] = mk(0, 1, 1,    1,   1,  0, 1, 0, 1, 0);
        tbl[38] = mk(0, 1, 1,    1,   1,  0, 1, 0, 2, 0);
        tbl[39] = mk(0, 0, 1,    1,   1,  0, 1, 1, 0, 75);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        window = '0; filter = '0; bias = '0;
        iv1 = 1'b0; ordy1 = 1'b1; w1 = '0; f1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            wb = 8'(tbl[n].w);
            fb = 8'(tbl[n].f);
            rst = tbl[n].rst; in_valid = tbl[n].iv; out_ready = tbl[n].ordy;
            window = {25{wb}};
            filter = {75{fb}};
            bias = 8'(tbl[n].b);
            #1;
            chk("in_ready", n, int'(in_ready), tbl[n].e_ir);
            chk("out_valid", n, int'(out_valid), tbl[n].e_ov);
            chk("ch_idx", n, int'(ch_idx), tbl[n].e_ch);
            chk("conv_value", n, int'($signed(conv_value)), relu(tbl[n].e_cv));
        end

        // Distinct elements: window[i]=i; ch0 picks i=24, ch1 weights i=3 by 2, ch2 sums all negated.
        for (int i = 0; i < 25; i++) window[8*i +: 8] = 8'(i);
        filter = '0;
        filter[8*24 +: 8] = 8'd1;
        filter[8*(25 + 3) +: 8] = 8'd2;
        for (int i = 0; i < 25; i++) filter[8*(50 + i) +: 8] = 8'hFF;
        bias = 8'hFF;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            #1 chk("placement ch_idx", n, int'(ch_idx), n);
        end
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("placement out_valid", 0, int'(out_valid), 1);
        chk("placement conv_value", 0, int'($signed(conv_value)), relu(-271));
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            #1;
            chk("hold in_ready", n, int'(in_ready), 0);
            chk("hold conv_value", n, int'($signed(conv_value)), relu(-271));
            chk("hold ch_idx", n, int'(ch_idx), 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("release in_ready", 0, int'(in_ready), 1);
        @(negedge clk);
        #1 chk("drained out_valid", 0, int'(out_valid), 0);

        // Single-channel instance: every beat is final, so pop and load share an edge.
        @(negedge clk);
        iv1 = 1'b1; ordy1 = 1'b1; w1 = 8'd3; f1 = 8'd4; b1 = 8'd1;
        @(negedge clk);
        w1 = 8'hFE; f1 = 8'd5; b1 = 8'd0;
        #1;
        chk("c1 out_valid", 0, int'(ov1), 1);
        chk("c1 conv_value", 0, int'($signed(cv1)), 13);
        chk("c1 in_ready", 0, int'(ir1), 1);
        @(negedge clk);
        w1 = 8'd7; f1 = 8'd7; b1 = 8'h80;
        #1;
        chk("c1 out_valid", 1, int'(ov1), 1);
        chk("c1 conv_value", 1, int'($signed(cv1)), relu(-10));
        chk("c1 ch_idx", 1, int'(ch1), 0);
        @(negedge clk);
        iv1 = 1'b0;
        #1;
        chk("c1 out_valid", 2, int'(ov1), 1);
        chk("c1 conv_value", 2, int'($signed(cv1)), relu(-79));
        @(negedge clk);
        #1 chk("c1 out_valid", 3, int'(ov1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
